// File: rtl/mips_loader.sv
// MiniMIPS program loader: streams host words into im, rf and dm,
// holding the core stalled until the whole image is written.
module mips_loader #(
    parameter int IM_DEPTH = 32,
    parameter int RF_DEPTH = 8,
    parameter int DM_DEPTH = 32,
    parameter int IM_AW    = 5,
    parameter int DM_AW    = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic             im_we,
    output logic [IM_AW-1:0] im_addr,
    output logic [15:0]      im_wdata,
    output logic             rf_we,
    output logic [2:0]       rf_addr,
    output logic [31:0]      rf_wdata,
    output logic             dm_we,
    output logic [DM_AW-1:0] dm_addr,
    output logic [31:0]      dm_wdata,
    output logic             busy,
    output logic             cpu_run
);

    localparam int AWM = (IM_AW > DM_AW) ? IM_AW : DM_AW;
    localparam int CW  = (AWM > 3) ? AWM : 3;
    localparam logic [CW-1:0] IM_LAST = CW'(IM_DEPTH - 1);
    localparam logic [CW-1:0] RF_LAST = CW'(RF_DEPTH - 1);
    localparam logic [CW-1:0] DM_LAST = CW'(DM_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_IM,
        S_LOAD_RF,
        S_LOAD_DM,
        S_FLUSH,
        S_RUN
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic             w_acc;
    logic             w_last;
    logic             w_restart;

    logic             r_im_we;
    logic [IM_AW-1:0] r_im_addr;
    logic [15:0]      r_im_wdata;
    logic             r_rf_we;
    logic [2:0]       r_rf_addr;
    logic [31:0]      r_rf_wdata;
    logic             r_dm_we;
    logic [DM_AW-1:0] r_dm_addr;
    logic [31:0]      r_dm_wdata;

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        cpu_run   = 1'b0;
        w_last    = 1'b0;
        w_restart = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_restart = start;
                if (start) w_next = S_LOAD_IM;
            end
            S_LOAD_IM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                w_last   = (r_cnt == IM_LAST);
                if (in_valid && w_last) w_next = S_LOAD_RF;
            end
            S_LOAD_RF: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                w_last   = (r_cnt == RF_LAST);
                if (in_valid && w_last) w_next = S_LOAD_DM;
            end
            S_LOAD_DM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                w_last   = (r_cnt == DM_LAST);
                if (in_valid && w_last) w_next = S_FLUSH;
            end
            S_FLUSH: begin
                busy   = 1'b1;
                w_next = S_RUN;
            end
            S_RUN: begin
                cpu_run   = 1'b1;
                w_restart = start;
                if (start) w_next = S_LOAD_IM;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_acc = in_valid & in_ready;

    always_ff @(posedge clock) begin
        if (reset || w_restart) r_cnt <= '0;
        else if (w_acc)         r_cnt <= w_last ? '0 : r_cnt + CW'(1);
    end

    // Strobes are registered, so a word taken on a reset edge never writes.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_im_we    <= 1'b0;
            r_im_addr  <= '0;
            r_im_wdata <= '0;
            r_rf_we    <= 1'b0;
            r_rf_addr  <= '0;
            r_rf_wdata <= '0;
            r_dm_we    <= 1'b0;
            r_dm_addr  <= '0;
            r_dm_wdata <= '0;
        end else begin
            r_im_we <= w_acc && (r_state == S_LOAD_IM);
            r_rf_we <= w_acc && (r_state == S_LOAD_RF) && (r_cnt != '0);
            r_dm_we <= w_acc && (r_state == S_LOAD_DM);
            if (w_acc && (r_state == S_LOAD_IM)) begin
                r_im_addr  <= r_cnt[IM_AW-1:0];
                r_im_wdata <= in_data[15:0];
            end
            if (w_acc && (r_state == S_LOAD_RF)) begin
                r_rf_addr  <= r_cnt[2:0];
                r_rf_wdata <= in_data;
            end
            if (w_acc && (r_state == S_LOAD_DM)) begin
                r_dm_addr  <= r_cnt[DM_AW-1:0];
                r_dm_wdata <= in_data;
            end
        end
    end

    assign im_we    = r_im_we;
    assign im_addr  = r_im_addr;
    assign im_wdata = r_im_wdata;
    assign rf_we    = r_rf_we;
    assign rf_addr  = r_rf_addr;
    assign rf_wdata = r_rf_wdata;
    assign dm_we    = r_dm_we;
    assign dm_addr  = r_dm_addr;
    assign dm_wdata = r_dm_wdata;

endmodule

// File: tb/tb_mips_loader.sv
// Scoreboard bench for mips_loader: driver queues expected writes,
// a negedge monitor pops and compares each strobe.
module tb_mips_loader;

    typedef struct packed {
        logic [1:0]  port;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        im_we;
    logic [4:0]  im_addr;
    logic [15:0] im_wdata;
    logic        rf_we;
    logic [2:0]  rf_addr;
    logic [31:0] rf_wdata;
    logic        dm_we;
    logic [4:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic        busy;
    logic        cpu_run;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;
    int  dt;

    mips_loader dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .rf_we    (rf_we),
        .rf_addr  (rf_addr),
        .rf_wdata (rf_wdata),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .busy     (busy),
        .cpu_run  (cpu_run)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Hand-derived mapping of stream index k to the write it must cause.
    function automatic wr_t model(int k, logic [31:0] d);
        wr_t w;
        if (k < 32) begin
            w.port = 2'd0;
            w.addr = 5'(k);
            w.data = {16'h0, d[15:0]};
        end else if (k < 40) begin
            w.port = 2'd1;
            w.addr = 5'(k - 32);
            w.data = d;
        end else begin
            w.port = 2'd2;
            w.addr = 5'(k - 40);
            w.data = d;
        end
        return w;
    endfunction

    always @(negedge clock) begin
        wr_t act;
        wr_t e;
        if (im_we || rf_we || dm_we) begin
            act.port = im_we ? 2'd0 : (rf_we ? 2'd1 : 2'd2);
            act.addr = im_we ? im_addr : (rf_we ? {2'b0, rf_addr} : dm_addr);
            act.data = im_we ? {16'h0, im_wdata} : (rf_we ? rf_wdata : dm_wdata);
            if ($countones({im_we, rf_we, dm_we}) > 1 || cpu_run) begin
                chk("strobe_excl", {cpu_run, im_we, rf_we, dm_we}, 64'h0);
            end else if (exp_q.size() == 0) begin
                chk("unexpected_write", 64'(act), 64'h0);
            end else begin
                e = exp_q.pop_front();
                chk("write", 64'(act), 64'(e));
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic send(int k, logic [31:0] d, bit gap);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clock);
        if (k != 32) exp_q.push_back(model(k, d));
        #1;
        in_valid = 1'b0;
        in_data  = '0;
        start    = 1'b0;
        if (gap) begin
            @(posedge clock);
            #1;
        end
    endtask

    function automatic logic [31:0] word(int k);
        return (k == 3) ? 32'hABCD_1234 : 32'(k);
    endfunction

    task automatic load(bit gaps, bit midstart, output int t);
        int s;
        pulse_start();
        s = cyc;
        chk("after_start", {in_ready, busy, cpu_run}, 3'b110);
        for (int k = 0; k < 72; k++) begin
            if (midstart && k == 5) start = 1'b1;
            send(k, word(k), gaps && k >= 32 && k < 40 && (k % 2 == 1));
        end
        t = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (cpu_run) begin
                t = cyc - s;
                break;
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("reset_state",
            {in_ready, busy, cpu_run, im_we, rf_we, dm_we,
             im_addr, rf_addr, dm_addr, im_wdata},
            64'h0);
        chk("reset_wdata", {rf_wdata, dm_wdata}, 64'h0);
        reset = 1'b0;

        in_valid = 1'b1;
        in_data  = 32'h5555_AAAA;
        repeat (10) @(posedge clock);
        #1;
        chk("idle_no_ready", {in_ready, busy, cpu_run}, 3'b000);
        in_valid = 1'b0;

        load(1'b0, 1'b0, dt);
        chk("run_latency_73", 64'(dt), 64'd73);
        chk("run_state", {in_ready, busy, cpu_run}, 3'b001);

        load(1'b1, 1'b1, dt);
        chk("gap_run_latency", 64'(dt), 64'd77);

        pulse_start();
        for (int k = 0; k < 50; k++) send(k, word(k), 1'b0);
        in_valid = 1'b1;
        in_data  = 32'd50;
        reset    = 1'b1;
        @(posedge clock);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("reset_mid_load", {in_ready, busy, cpu_run}, 3'b000);
        repeat (5) @(posedge clock);
        #1;
        chk("post_reset_idle", {cpu_run, im_addr, rf_addr, dm_addr}, 64'h0);

        load(1'b0, 1'b0, dt);
        chk("reload_latency", 64'(dt), 64'd73);

        repeat (4) @(posedge clock);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("final_run", {busy, cpu_run}, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_loader.md
# mips_loader

Hardware program loader for MiniMIPS: the writer-side counterpart of the bench's state dump and load. Accepts a stream of 32-bit words over a valid/ready handshake and writes them, in fixed order, into instruction memory, the register file and data memory. Holds the core stalled through `cpu_run` until every word is written, then releases it. It sits between an external host link and the write ports of `im`, `rm` and `data`.

## Interface
- `IM_DEPTH`, 32: instruction-memory words loaded. Only the low 16 bits of each stream word are used.
- `RF_DEPTH`, 8: register-file entries loaded.
- `DM_DEPTH`, 32: data-memory words loaded.
- `IM_AW`, 5: instruction address width.
- `DM_AW`, 5: data address width.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: single-cycle request to begin a load.
- `in_valid` in 1: host word valid.
- `in_data` in 32: host word.
- `in_ready` out 1: loader accepts a word this cycle.
- `im_we` out 1, `im_addr` out IM_AW, `im_wdata` out 16: instruction memory write port.
- `rf_we` out 1, `rf_addr` out 3, `rf_wdata` out 32: register-file write port.
- `dm_we` out 1, `dm_addr` out DM_AW, `dm_wdata` out 32: data memory write port.
- `busy` out 1: a load is in progress, FLUSH included.
- `cpu_run` out 1: core may fetch and execute.

## Operation
- States:
  - IDLE: after reset.
  - LOAD_IM, LOAD_RF, LOAD_DM: one per target.
  - FLUSH: one cycle.
  - RUN: core released.
- Transitions:
  - IDLE or RUN with `start`=1 → LOAD_IM. The word counter clears and `cpu_run` drops.
  - `start` is ignored in LOAD_*/FLUSH.
- Accept = `in_valid & in_ready`. `in_ready` = 1 only in LOAD_* states and is a pure decode of state.
- Each accepted word:
  - Is registered with the current counter as address.
  - Increments the counter.
  - Produces a one-cycle write strobe on the port for the current phase, with addr and wdata stable during the strobe.
- Phase end:
  - When the accepted word has counter = DEPTH−1 for that phase, the state advances at the same edge: LOAD_IM → LOAD_RF → LOAD_DM → FLUSH.
  - The counter resets to 0 at that edge.
- Register $0:
  - Its word is consumed and the counter advances.
  - `rf_we` stays 0 for address 0, so $0 is never written.
- `im_wdata` = `in_data[15:0]`. Bits 31:16 are discarded in LOAD_IM.
- FLUSH → RUN unconditionally after one cycle. This lets the final `dm_we` strobe complete before the core starts.
- At most one write strobe is high in any cycle. Strobes never overlap the core's run window.

## Timing
- Reset values (all outputs):
  - State = IDLE.
  - `in_ready`, `busy`, `cpu_run` = 0.
  - All `*_we` = 0.
  - All addr/wdata = 0.
  - Counter = 0.
- Reset mid-load:
  - Returns to IDLE at that edge.
  - A strobe that would follow a word accepted at the reset edge is suppressed.
  - `cpu_run` stays 0 until a full new load completes.
- Write latency: word accepted at edge N; strobe high from N to N+1 (1-cycle latency). Back-to-back acceptance gives one write per cycle.
- `in_valid` low: no accept, counter holds, no strobe. Gaps of any length are legal.
- `start` edge N: `in_ready` = 1 and `busy` = 1 from N.
- Minimum load time = IM_DEPTH+RF_DEPTH+DM_DEPTH+1 cycles from `start` to RUN. With defaults, `cpu_run` rises 73 cycles after the `start` edge with continuous `in_valid`.
- `busy` = 1 in LOAD_*/FLUSH. `cpu_run` = 1 only in RUN.
- Counter width = max(IM_AW, DM_AW, 3). Compare against DEPTH−1 exactly. No wrap beyond depth.

## Test plan
- Continuous stream of 72 words with defaults, `in_data` = index:
  - `im_we` addr 0..31 with wdata 0..31.
  - `rf_we` addr 1..7 with wdata 33..39. Addr 0 is never strobed.
  - `dm_we` addr 0..31 with wdata 40..71.
  - `cpu_run` = 1 exactly 73 cycles after `start`.
- `in_valid` toggled 1-0-1-0 during LOAD_RF:
  - Strobes only on accepting cycles.
  - Addresses contiguous. Total rf strobes = 7.
- `in_data`=32'hABCD_1234 at IM addr 3: `im_wdata` = 16'h1234 at addr 3.
- Reset asserted on the edge accepting DM word 10:
  - No `dm_we` follows.
  - Next cycle `in_ready`=0, `busy`=0, `cpu_run`=0.
  - A subsequent full load succeeds.
- `start` pulsed during LOAD_IM:
  - Ignored; counter unaffected.
  - `start` in RUN drops `cpu_run` next cycle and restarts at IM addr 0.
- Idle with `in_valid`=1 and no `start`: `in_ready`=0, no strobes, `cpu_run`=0 indefinitely.
